hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline control block for the 5-stage 20-bit core (IF/ID/EX/MEM/WB). It sequences stage-register enables, bubbles and flushes.
- Detects load-use hazards the forwarding unit cannot cover and squashes the IF instruction on ID-resolved jumps/branches.
- Freezes the pipe while the data memory is busy and parks the core when the PC reaches the halt address.
- Sits beside the datapath; consumes ID/EX/MEM fields and drives the enables of the PC and the four stage registers.

Parameters:
- REG_NUMBER, 5, register index width.
- ADDRESS_WIDTH, 8, PC width.
- HALT_ADDR, 8'hFA, PC value at or above which the core halts.
- MAX_WAIT, 16, memory-wait timeout limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_NUMBER  source register 1 of the instruction in ID.
- id_rs2  in  REG_NUMBER  source register 2 of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2 (RegSrc/ALUSrc-qualified).
- ex_rd  in  REG_NUMBER  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- branch_taken  in  1  ID jump/branch resolved taken (sel0).
- mem_req  in  1  MEM stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc  in  ADDRESS_WIDTH  current PC.
- pc_we  out  1  PC register write enable.
- if_id_we  out  1  IF/ID write enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_we  out  1  ID/EX write enable.
- id_ex_bubble  out  1  clear ID/EX control bits (RegWrite/MemRead/MemWrite=0).
- ex_mem_we  out  1  EX/MEM write enable.
- mem_wb_bubble  out  1  clear MEM/WB RegWrite.
- branch_en  out  1  gate for PC mux select; 0 suppresses the jump.
- halted  out  1  core parked.
- mem_timeout  out  1  sticky timeout flag (0 when feature is compiled out).
- stall_count  out  16  saturating count of stall cycles.

Behaviour:
- FSM states: RUN, LOAD_STALL, MEM_WAIT, HALT. Outputs are combinational from the state and inputs.
- Reset, while rst=0:
  - State forced to RUN; stall_count=0; mem_timeout=0.
  - All *_we=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1, branch_en=0, halted=0.
- Load-use hazard: hz = ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- RUN, priority top to bottom:
  1. pc>=HALT_ADDR → HALT; enables 0 this cycle.
  2. mem_req & !mem_ready → MEM_WAIT. This cycle: all *_we=0, mem_wb_bubble=1, branch_en=0.
  3. hz → LOAD_STALL. This cycle: pc_we=0, if_id_we=0, id_ex_bubble=1, branch_en=0, id_ex_we=1, ex_mem_we=1.
  4. branch_taken → stay RUN; all we=1, branch_en=1, if_id_flush=1 (exactly one cycle).
  5. Otherwise all we=1, bubbles/flush=0, branch_en=1.
- LOAD_STALL:
  - Lasts exactly one cycle, then → RUN; outputs as RUN item 5.
  - The stalled instruction re-evaluates in RUN, where hz is then false because the load has moved to MEM.
  - A branch stalled by hz is honoured on that re-evaluation, never earlier.
- MEM_WAIT:
  - All *_we=0, mem_wb_bubble=1, branch_en=0.
  - On mem_ready=1: that cycle all we=1 and branch_en=1, then → RUN.
  - mem_req dropping without mem_ready → RUN.
- HALT: all we=0, bubbles=1, branch_en=0, halted=1. Only reset exits.
- stall_count:
  - +1 on every posedge where pc_we=0 and state≠HALT.
  - Saturates at 16'hFFFF, no wrap.
- A simultaneous hazard and branch is a single event: the stall wins and the branch is deferred, never lost.
- Reset asserted mid-MEM_WAIT or mid-LOAD_STALL aborts immediately; no pending state survives.

Optional Feature:
- HAZARD_SEQUENCER_MEM_TIMEOUT_EN defined:
  - 16-bit wait counter cleared on MEM_WAIT entry, +1 per MEM_WAIT cycle.
  - On reaching MAX_WAIT without mem_ready: mem_timeout=1 (sticky until reset), → HALT.
- Undefined: no counter; MEM_WAIT waits indefinitely; mem_timeout tied 0.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 → one cycle pc_we=0, if_id_we=0, id_ex_bubble=1; next cycle all we=1; stall_count=1.
- No hazard: ex_rd=0 with id_rs1=0, ex_mem_read=1 → no stall. Also id_uses_rs2=0 with ex_rd==id_rs2=7 → no stall.
- Branch: branch_taken=1, no hazard → if_id_flush=1 for one cycle, branch_en=1. Hazard and branch_taken together → branch_en=0, stall, then flush on the following cycle.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → 3 frozen cycles with mem_wb_bubble=1, then resume; stall_count=3.
- Halt: pc=8'hFA → halted=1 and all we=0 for 10 cycles; deassert-assert rst → RUN, halted=0, stall_count=0.
- MEM_TIMEOUT_EN, MAX_WAIT=16: mem_ready held 0 → mem_timeout=1 and halted=1 after the 16th wait cycle; reset mid-wait at cycle 8 → flag stays 0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline control: stage enables, bubbles and flushes for the 5-stage core.
// Optional memory-wait timeout: define HAZARD_SEQUENCER_MEM_TIMEOUT_EN.
module hazard_sequencer #(
  parameter int REG_NUMBER = 5,
  parameter int ADDRESS_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] HALT_ADDR = 8'hFA,
  parameter int MAX_WAIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_NUMBER-1:0]    id_rs1,
  input  logic [REG_NUMBER-1:0]    id_rs2,
  input  logic                     id_uses_rs2,
  input  logic [REG_NUMBER-1:0]    ex_rd,
  input  logic                     ex_mem_read,
  input  logic                     branch_taken,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     pc_we,
  output logic                     if_id_we,
  output logic                     if_id_flush,
  output logic                     id_ex_we,
  output logic                     id_ex_bubble,
  output logic                     ex_mem_we,
  output logic                     mem_wb_bubble,
  output logic                     branch_en,
  output logic                     halted,
  output logic                     mem_timeout,
  output logic [15:0]              stall_count
);

  typedef enum logic [1:0] {
    RUN, LOAD_STALL, MEM_WAIT, HALT
  } state_t;

  state_t state, state_nx;
  logic   hz;
  logic   wait_done;

  assign hz = ex_mem_read && (ex_rd != '0) &&
              (ex_rd == id_rs1 ||
               (id_uses_rs2 && ex_rd == id_rs2));

`ifdef HAZARD_SEQUENCER_MEM_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_q;

  assign wait_done = (wait_cnt == 16'(MAX_WAIT - 1));
  assign mem_timeout = timeout_q;

  // wait_cnt sits at zero outside MEM_WAIT, so entry clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state != MEM_WAIT) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ready) begin
      if (wait_done) timeout_q <= 1'b1;
      else wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  logic unused_max;
  assign unused_max = (MAX_WAIT != 0);
  assign wait_done = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    branch_en     = 1'b1;
    halted        = 1'b0;
    if (!rst) begin
      state_nx      = RUN;
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
      branch_en     = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (pc >= HALT_ADDR) begin
            state_nx      = HALT;
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
            branch_en     = 1'b0;
          end else if (mem_req && !mem_ready) begin
            state_nx      = MEM_WAIT;
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_bubble = 1'b1;
            branch_en     = 1'b0;
          end else if (hz) begin
            // branch is deferred to the re-evaluation cycle
            state_nx     = LOAD_STALL;
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            branch_en    = 1'b0;
          end else begin
            if_id_flush = branch_taken;
          end
        end
        LOAD_STALL: begin
          state_nx    = RUN;
          if_id_flush = branch_taken;
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_nx = RUN;
          end else begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_bubble = 1'b1;
            branch_en     = 1'b0;
            if (!mem_req) state_nx = RUN;
            else if (wait_done) state_nx = HALT;
          end
        end
        HALT: begin
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_ex_we      = 1'b0;
          ex_mem_we     = 1'b0;
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b1;
          mem_wb_bubble = 1'b1;
          branch_en     = 1'b0;
          halted        = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      if (!pc_we && state != HALT && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed and random checks of hazard_sequencer against a behavioural model.
// Timeout checks are active when HAZARD_SEQUENCER_MEM_TIMEOUT_EN is defined.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs2 = 0, ex_mem_read = 0, branch_taken = 0;
  logic       mem_req = 0, mem_ready = 0;
  logic [7:0] pc = 8'h10;
  logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
  logic       ex_mem_we, mem_wb_bubble, branch_en, halted, mem_timeout;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  hazard_sequencer dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc(pc),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble),
    .ex_mem_we(ex_mem_we), .mem_wb_bubble(mem_wb_bubble),
    .branch_en(branch_en), .halted(halted),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  // {pc_we,if_id_we,flush,id_ex_we,idb,ex_mem_we,mwb,branch_en,halted}
  localparam logic [8:0] V_RUN   = 9'b110101010;
  localparam logic [8:0] V_STALL = 9'b000111000;
  localparam logic [8:0] V_FROZE = 9'b000000100;
  localparam logic [8:0] V_PARK  = 9'b001010100;
  localparam logic [8:0] V_HALT  = 9'b001010101;
  localparam int LIMIT = 16;

  int checks = 0, errors = 0;
  logic [8:0] act;
  assign act = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
                ex_mem_we, mem_wb_bubble, branch_en, halted};

  // model: what happened last cycle, and how long memory has been waited on
  bit m_after_load, m_waiting, m_parked, m_to;
  int m_wait, m_sc;
`ifdef HAZARD_SEQUENCER_MEM_TIMEOUT_EN
  bit to_en = 1'b1;
`else
  bit to_en = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outs", 32'(act), 32'(V_PARK));
    check("reset_sc", 32'(stall_count), 0);
    check("reset_to", 32'(mem_timeout), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    m_after_load = 0; m_waiting = 0; m_parked = 0;
    m_to = 0; m_wait = 0; m_sc = 0;
  endtask

  task automatic step(input logic [4:0] r1, input logic [4:0] r2,
                      input logic u2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic mq,
                      input logic rdy, input logic [7:0] p);
    logic [8:0] e;
    bit hzb, n_load, n_wait, n_park, n_to;
    int n_w;
    @(negedge clk);
    id_rs1 = r1; id_rs2 = r2; id_uses_rs2 = u2; ex_rd = rd;
    ex_mem_read = mr; branch_taken = br; mem_req = mq;
    mem_ready = rdy; pc = p;
    #1;
    hzb = mr && rd != 0 && (rd == r1 || (u2 && rd == r2));
    n_load = 0; n_wait = m_waiting; n_park = m_parked;
    n_to = m_to; n_w = m_wait;
    e = V_RUN;
    if (m_parked) e = V_HALT;
    else if (m_waiting) begin
      if (rdy) n_wait = 0;
      else begin
        e = V_FROZE;
        if (!mq) n_wait = 0;
        else if (to_en && m_wait == LIMIT - 1) begin
          n_to = 1; n_park = 1; n_wait = 0;
        end else n_w = m_wait + 1;
      end
    end else if (m_after_load) e[6] = br;
    else if (p >= 8'hFA) begin e = V_PARK; n_park = 1; end
    else if (mq && !rdy) begin e = V_FROZE; n_wait = 1; n_w = 0; end
    else if (hzb) begin e = V_STALL; n_load = 1; end
    else e[6] = br;
    check("outs", 32'(act), 32'(e));
    check("stall_count", 32'(stall_count), 32'(m_sc));
    check("mem_timeout", 32'(mem_timeout), 32'(m_to));
    @(posedge clk);
    if (!e[8] && !m_parked && m_sc < 65535) m_sc++;
    m_after_load = n_load; m_waiting = n_wait; m_parked = n_park;
    m_to = n_to; m_wait = n_w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 2, 1, 3, 0, 0, 0, 0, 8'h10);
  endtask

  initial begin
    int halt_run;
    do_reset();
    idle(2);
    // load-use on rs1
    step(5, 0, 0, 5, 1, 0, 0, 0, 8'h12);
    check("load_stall_pcwe", 32'(pc_we), 0);
    step(5, 0, 0, 9, 0, 0, 0, 0, 8'h12);
    check("load_resume_pcwe", 32'(pc_we), 1);
    step(1, 2, 0, 3, 0, 0, 0, 0, 8'h13);
    check("load_sc", 32'(stall_count), 1);
    // no hazard with x0 and with unused rs2
    step(0, 0, 1, 0, 1, 0, 0, 0, 8'h14);
    step(1, 7, 0, 7, 1, 0, 0, 0, 8'h15);
    check("no_hz_sc", 32'(stall_count), 1);
    // plain branch, then hazard coinciding with branch
    step(1, 2, 1, 3, 0, 1, 0, 0, 8'h16);
    check("branch_flush", 32'(if_id_flush), 1);
    step(4, 2, 1, 4, 1, 1, 0, 0, 8'h17);
    check("hz_br_en", 32'(branch_en), 0);
    step(4, 2, 1, 9, 0, 1, 0, 0, 8'h17);
    check("deferred_flush", 32'(if_id_flush), 1);
    // memory wait
    do_reset();
    repeat (3) step(1, 2, 1, 3, 0, 0, 1, 0, 8'h20);
    step(1, 2, 1, 3, 0, 0, 1, 1, 8'h20);
    check("mw_resume_we", 32'(pc_we), 1);
    idle(1);
    check("mw_sc", 32'(stall_count), 3);
    // mem_req dropping without ready
    step(1, 2, 1, 3, 0, 0, 1, 0, 8'h21);
    step(1, 2, 1, 3, 0, 0, 0, 0, 8'h21);
    idle(1);
    // halt
    repeat (11) step(1, 2, 1, 3, 0, 0, 0, 0, 8'hFA);
    check("halted", 32'(halted), 1);
    do_reset();
    idle(1);
    check("post_halt", 32'(halted), 0);
    // reset aborting a load stall and a long memory wait
    step(6, 0, 0, 6, 1, 1, 0, 0, 8'h30);
    do_reset();
    step(6, 0, 0, 9, 0, 0, 0, 0, 8'h30);
    repeat (8) step(1, 2, 1, 3, 0, 0, 1, 0, 8'h31);
    do_reset();
    check("to_after_rst", 32'(mem_timeout), 0);
    idle(1);
`ifdef HAZARD_SEQUENCER_MEM_TIMEOUT_EN
    repeat (17) step(1, 2, 1, 3, 0, 0, 1, 0, 8'h40);
    idle(2);
    check("timeout_flag", 32'(mem_timeout), 1);
    check("timeout_halt", 32'(halted), 1);
    do_reset();
`endif
    // random traffic
    halt_run = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_parked && ++halt_run > 3) begin
        do_reset();
        halt_run = 0;
      end
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           1'($urandom_range(0, 9) < 3), 1'($urandom),
           ($urandom_range(0, 59) == 0) ? 8'hFC
                                        : 8'($urandom_range(0, 8'hF9)));
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
